// File: rtl/uart_rx_if.sv
// Purpose : bundles the serial-side inputs and received-word outputs of the UART receiver.
// Latency : none (wiring only).
// Backpressure: none; data_valid/framing_error are one-clk strobes the consumer must catch.
// Ports   : sample_tick, rx       -> into the receiver (slave modport inputs)
//           data_out, data_valid, framing_error, busy -> out of the receiver
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 framing_error;
    logic                 busy;

    // master: the environment (baud generator, line, word consumer)
    modport master (
        output sample_tick,
        output rx,
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  busy
    );

    // slave: the receiver itself
    modport slave (
        input  sample_tick,
        input  rx,
        output data_out,
        output data_valid,
        output framing_error,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// Purpose : 16x-oversampled UART receiver (DATA_BITS data, no parity, 1 stop, LSB first).
// Latency : data_valid on the tick at mid stop bit, ~(DATA_BITS+1.5)*OVERSAMPLE ticks + 2 clk after start edge.
// Backpressure: none; each word is presented with a single-clk strobe and held until the next good frame.
// Ports   : clk, reset (async, active-high); bus.slave carries sample_tick, rx in and
//           data_out, data_valid, framing_error, busy out.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    uart_rx_if.slave   bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_meta;
    logic                 rx_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Sync flops reset to the idle line level so reset release never looks like a start bit.
            rx_meta           <= 1'b1;
            rx_sync           <= 1'b1;
            state             <= IDLE;
            tick_cnt          <= '0;
            bit_cnt           <= '0;
            shift_reg         <= '0;
            bus.data_out      <= '0;
            bus.data_valid    <= 1'b0;
            bus.framing_error <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            rx_meta           <= bus.rx;
            rx_sync           <= rx_meta;
            // Strobes clear on every clk, independent of sample_tick.
            bus.data_valid    <= 1'b0;
            bus.framing_error <= 1'b0;

            if (bus.sample_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_sync) begin
                            state    <= START;
                            tick_cnt <= '0;
                            bus.busy <= 1'b1;
                        end
                    end

                    START: begin
                        if (tick_cnt == TICK_MID) begin
                            if (!rx_sync) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                // Line went back high before mid start bit: treat as a glitch.
                                state    <= IDLE;
                                tick_cnt <= '0;
                                bus.busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            // Counting a full bit from mid start lands on the middle of each data bit.
                            shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                            tick_cnt  <= '0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (tick_cnt == TICK_LAST) begin
                            // Leave at mid stop bit so the next start edge is never missed.
                            state    <= IDLE;
                            tick_cnt <= '0;
                            bus.busy <= 1'b0;
                            if (rx_sync) begin
                                bus.data_out   <= shift_reg;
                                bus.data_valid <= 1'b1;
                            end else begin
                                bus.framing_error <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Purpose : randomized + directed bench for uart_rx against a frame-level reference model.
// Latency : n/a.
// Backpressure: n/a; every received strobe is matched against the queue of frames sent.
module tb_uart_rx;
    localparam int DB = 8;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic reset;

    uart_rx_if #(.DATA_BITS(DB)) bus();

    uart_rx #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int tick_div = 4;
    bit tick_en  = 1'b0;

    // Reference model: one entry per frame put on the line, in order.
    typedef struct {
        bit            is_err;
        logic [DB-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DB-1:0] last_good;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // sample_tick generator: one clk high every tick_div clk while enabled.
    initial begin
        int cnt;
        cnt = 0;
        bus.sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en && cnt >= tick_div - 1) begin
                bus.sample_tick = 1'b1;
                cnt = 0;
            end else begin
                bus.sample_tick = 1'b0;
                if (tick_en) cnt++;
            end
        end
    end

    // Returns just after the n-th sample_tick edge, so rx changes land right after a tick.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (bus.sample_tick !== 1'b1);
        end
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        bus.rx = v;
        wait_ticks(n);
    endtask

    task automatic push_exp(input logic [DB-1:0] d, input logic stop);
        exp_t e;
        if (stop) begin
            e.is_err  = 1'b0;
            e.data    = d;
            last_good = d;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;   // a bad frame must leave data_out untouched
        end
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop);
        push_exp(d, stop);
        drive_bit(1'b0, OS);
        for (int i = 0; i < DB; i++) drive_bit(d[i], OS);
        drive_bit(stop, OS);
    endtask

    // Monitor: every strobe must match the oldest outstanding frame.
    initial begin
        exp_t e;
        logic prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && (bus.data_valid === 1'b1 || bus.framing_error === 1'b1)) begin
                check("strobe_exclusive", 32'(bus.data_valid & bus.framing_error), 0);
                check("strobe_one_clk", 32'(prev_pulse), 0);
                check("busy_low_at_strobe", 32'(bus.busy), 0);
                check("frame_outstanding", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("strobe_kind_ferr", 32'(bus.framing_error), 32'(e.is_err));
                    check("data_out", 32'(bus.data_out), 32'(e.data));
                end
            end
            prev_pulse = bus.data_valid | bus.framing_error;
        end
    end

    // Hard stop if something wedges.
    initial begin
        #(99000 * 10);
        $display("FAIL watchdog: simulation did not complete");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] d;
        logic          stop;
        int            gap;
        int            busy_clk;

        bus.rx    = 1'b1;
        reset     = 1'b1;
        last_good = '0;
        repeat (5) @(negedge clk);
        check("rst_data_out", 32'(bus.data_out), 0);
        check("rst_data_valid", 32'(bus.data_valid), 0);
        check("rst_framing_error", 32'(bus.framing_error), 0);
        check("rst_busy", 32'(bus.busy), 0);
        reset   = 1'b0;
        tick_en = 1'b1;
        wait_ticks(2);

        // Good frame, then a frame with a low stop bit.
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, OS);
        check("drain_a5", 32'(exp_q.size()), 0);
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b1, 2 * OS);
        check("drain_3c", 32'(exp_q.size()), 0);
        check("hold_after_ferr", 32'(bus.data_out), 32'(8'hA5));

        // Start-bit glitch: busy only for the half bit up to the mid-start check.
        busy_clk = 0;
        fork
            begin
                drive_bit(1'b0, 3);
                drive_bit(1'b1, 2 * OS);
            end
            begin
                repeat (30 * tick_div) begin
                    @(negedge clk);
                    if (bus.busy === 1'b1) busy_clk++;
                end
            end
        join
        check("glitch_busy_clk", 32'(busy_clk), 32'((OS / 2) * tick_div));
        check("glitch_data_hold", 32'(bus.data_out), 32'(8'hA5));

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive_bit(1'b1, OS);
        check("drain_b2b", 32'(exp_q.size()), 0);

        // Reset in the middle of 0x96 after four data bits.
        d = 8'h96;
        drive_bit(1'b0, OS);
        for (int i = 0; i < 4; i++) drive_bit(d[i], OS);
        check("busy_before_reset", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_data_out", 32'(bus.data_out), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_data_valid", 32'(bus.data_valid), 0);
        check("mid_rst_framing_error", 32'(bus.framing_error), 0);
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        last_good = '0;
        wait_ticks(2);
        send_frame(8'h5A, 1'b1);
        drive_bit(1'b1, OS);
        check("drain_5a", 32'(exp_q.size()), 0);

        // Ticks stop mid-bit while the line toggles; state must not move.
        d = 8'($urandom);
        push_exp(d, 1'b1);
        drive_bit(1'b0, OS);
        for (int i = 0; i < 4; i++) drive_bit(d[i], OS);
        drive_bit(d[4], 6);
        tick_en = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            bus.rx = 1'($urandom);
        end
        check("stall_busy", 32'(bus.busy), 1);
        check("stall_no_strobe", 32'(exp_q.size()), 1);
        bus.rx = d[4];
        repeat (4) @(negedge clk);
        tick_en = 1'b1;
        wait_ticks(OS - 6);
        for (int i = 5; i < DB; i++) drive_bit(d[i], OS);
        drive_bit(1'b1, OS);
        drive_bit(1'b1, OS);
        check("drain_stall", 32'(exp_q.size()), 0);

        // Random frames, random stop-bit validity, random idle gaps.
        for (int f = 0; f < 12; f++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(3) != 0);
            send_frame(d, stop);
            gap  = stop ? $urandom_range(2) * (OS / 2) : OS + $urandom_range(OS);
            if (gap > 0) drive_bit(1'b1, gap);
        end
        drive_bit(1'b1, OS);
        check("drain_random", 32'(exp_q.size()), 0);

        // Real-rate divisor: 50 MHz / (9600 * 16) ~= 326 clk per tick.
        tick_div = 326;
        wait_ticks(2);
        send_frame(8'($urandom), 1'b1);
        drive_bit(1'b1, 2);
        tick_div = 4;

        for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(negedge clk);
        check("all_frames_seen", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
